// File: rtl/speed_tick_gen.sv
// speed_tick_gen
// Per-channel step-rate generator for the maze game movers (Pac-Man plus
// ghosts). Each channel owns a period counter whose period is chosen from the
// channel's game mode and the shared power-bean level. A one-cycle tick is
// emitted every period. A mode change or a sync request restarts the count.
// o_period is a registered copy of the period currently in force.

module speed_tick_gen #(
    parameter int N_CH        = 5,
    parameter int CNT_W       = 28,
    parameter     BASE_PERIOD = 28'd6250000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [2:0]              i_bean,
    input  logic [4*N_CH-1:0]       i_mode,
    input  logic [N_CH-1:0]         i_sync,
    output logic [N_CH-1:0]         o_tick,
    output logic [CNT_W*N_CH-1:0]   o_period
);

    // Game mode codes
    localparam logic [3:0] MODE_IDLE       = 4'd0;
    localparam logic [3:0] MODE_CHASE      = 4'd1;
    localparam logic [3:0] MODE_SCATTER    = 4'd2;
    localparam logic [3:0] MODE_FRIGHTENED = 4'd3;
    localparam logic [3:0] MODE_DIED       = 4'd4;
    localparam logic [3:0] MODE_PAUSE      = 4'd5;

    // Period ladder. All faster speeds are derived from the base period by
    // shifting, so the base must divide cleanly by 8.
    localparam logic [CNT_W-1:0] B_FULL   = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] B_HALF   = B_FULL >> 3'd1;
    localparam logic [CNT_W-1:0] B_QUART  = B_FULL >> 3'd2;
    localparam logic [CNT_W-1:0] B_EIGHTH = B_FULL >> 3'd3;
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    // Reject base periods that would give a zero or truncated period.
    if ((64'(BASE_PERIOD) % 64'd8) != 64'd0 ||
        64'(BASE_PERIOD) < 64'd16 ||
        64'(BASE_PERIOD) >= (64'd1 << CNT_W)) begin : g_bad_base_period
        $error("speed_tick_gen: BASE_PERIOD must be a multiple of 8, at least 16 and below 2**CNT_W");
    end

    // Period in force for a given mode and bean level.
    function automatic logic [CNT_W-1:0] sel_period(
        input logic [3:0] mode,
        input logic [2:0] bean
    );
        logic [CNT_W-1:0] p;
        p = B_FULL;
        case (mode)
            MODE_IDLE: begin
                p = B_HALF;
            end
            MODE_CHASE, MODE_SCATTER: begin
                // Only the three "thermometer" bean codes speed a mover up.
                case (bean)
                    3'b001:  p = B_HALF;
                    3'b011:  p = B_QUART;
                    3'b111:  p = B_EIGHTH;
                    default: p = B_FULL;
                endcase
            end
            MODE_FRIGHTENED: begin
                p = B_HALF;
            end
            MODE_DIED: begin
                // Eyes returning home move fastest.
                p = B_EIGHTH;
            end
            MODE_PAUSE: begin
                p = B_FULL;
            end
            default: begin
                p = B_FULL;
            end
        endcase
        return p;
    endfunction

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [3:0]       mode_s;
        logic [CNT_W-1:0] period_s;
        logic [CNT_W-1:0] limit_s;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] cnt_q;
        logic             tick_d;
        logic             tick_q;
        logic [3:0]       prev_mode_q;
        logic [CNT_W-1:0] period_q;

        assign mode_s   = i_mode[4*k +: 4];
        assign period_s = sel_period(mode_s, i_bean);
        // Period is at least 2, so the subtraction never underflows.
        assign limit_s  = period_s - ONE_C;

        // Next counter/tick value, first matching rule wins.
        always_comb begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            if (i_sync[k]) begin
                // Sync beats everything, including a same-cycle wrap.
                cnt_d  = '0;
                tick_d = 1'b0;
            end else if (mode_s != prev_mode_q) begin
                cnt_d  = '0;
                tick_d = 1'b0;
            end else if (!i_en || (mode_s == MODE_PAUSE)) begin
                cnt_d  = cnt_q;
                tick_d = 1'b0;
            end else if (cnt_q >= limit_s) begin
                // ">=" also catches a count stranded above a newly
                // shortened period, so the counter never runs away.
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + ONE_C;
                tick_d = 1'b0;
            end
        end

        // Channel state: counter, tick, previous mode and published period.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                cnt_q       <= '0;
                tick_q      <= 1'b0;
                prev_mode_q <= MODE_IDLE;
                period_q    <= B_HALF;
            end else begin
                cnt_q       <= cnt_d;
                tick_q      <= tick_d;
                prev_mode_q <= mode_s;
                period_q    <= period_s;
            end
        end

        assign o_tick[k]                  = tick_q;
        assign o_period[k*CNT_W +: CNT_W] = period_q;
    end

endmodule

// File: tb/tb_speed_tick_gen.sv
// Self-checking bench for speed_tick_gen with two channels and a base period
// of 16. A cycle model feeds a scoreboard queue, and a table covers the period
// selection. Directed sequences cover the multi-cycle corner cases.

module tb_speed_tick_gen;

    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic [2:0]  i_bean;
    logic [7:0]  i_mode;
    logic [1:0]  i_sync;
    logic [1:0]  o_tick;
    logic [15:0] o_period;

    speed_tick_gen #(
        .N_CH        (2),
        .CNT_W       (8),
        .BASE_PERIOD (16)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_bean   (i_bean),
        .i_mode   (i_mode),
        .i_sync   (i_sync),
        .o_tick   (o_tick),
        .o_period (o_period)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] tick;
        logic [7:0] p0;
        logic [7:0] p1;
    } exp_t;

    typedef struct packed {
        logic [3:0] m0;
        logic [3:0] m1;
        logic [2:0] bean;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       tbl[12];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         mark     = 0;
    int         log0[$];
    int         log1[$];
    logic [1:0] prev_tick;
    int         m_cnt[2];
    logic [3:0] m_prev[2];
    logic [3:0] m0_v;
    logic [3:0] m1_v;
    logic [2:0] bean_v;
    logic       en_v;
    logic [1:0] sync_v;

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    // Reference period: base 16 shifted right by a speed-up amount.
    function automatic int m_period(input logic [3:0] m, input logic [2:0] b);
        int sh;
        sh = 0;
        if (m == 4'd0 || m == 4'd3) sh = 1;
        else if (m == 4'd4) sh = 3;
        else if (m == 4'd1 || m == 4'd2) begin
            if (b == 3'b001) sh = 1;
            else if (b == 3'b011) sh = 2;
            else if (b == 3'b111) sh = 3;
        end
        return 16 >> sh;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_prev[k] = 4'd0;
        end
        prev_tick = 2'b00;
    endtask

    // Predict the result of the coming rising edge and queue it.
    task automatic model_push();
        exp_t       e;
        logic [3:0] md;
        int         p;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            md = (k == 0) ? m0_v : m1_v;
            p  = m_period(md, bean_v);
            if (sync_v[k]) m_cnt[k] = 0;
            else if (md != m_prev[k]) m_cnt[k] = 0;
            else if (!en_v || md == 4'd5) m_cnt[k] = m_cnt[k];
            else if (m_cnt[k] + 1 >= p) begin
                m_cnt[k]  = 0;
                e.tick[k] = 1'b1;
            end else m_cnt[k] = m_cnt[k] + 1;
            m_prev[k] = md;
            if (k == 0) e.p0 = 8'(p);
            else        e.p1 = 8'(p);
        end
        sb_q.push_back(e);
    endtask

    // One clock: drive, predict, wait for the edge, compare, log ticks.
    task automatic step();
        exp_t e;
        i_mode = {m1_v, m0_v};
        i_bean = bean_v;
        i_en   = en_v;
        i_sync = sync_v;
        model_push();
        @(posedge i_clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_tick", int'(o_tick), int'(e.tick));
            chk("sb_period0", int'(o_period[7:0]), int'(e.p0));
            chk("sb_period1", int'(o_period[15:8]), int'(e.p1));
        end
        chk("tick_two_wide", int'(o_tick & prev_tick), 0);
        prev_tick = o_tick;
        if (o_tick[0]) log0.push_back(cyc - mark);
        if (o_tick[1]) log1.push_back(cyc - mark);
        sync_v = 2'b00;
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Mark the next edge as a counter restart and clear the tick logs.
    task automatic restart_mark();
        mark = cyc + 1;
        log0.delete();
        log1.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd0, 4'd4,  3'b000, 8'd8,  8'd2};
        tbl[1]  = '{4'd1, 4'd2,  3'b000, 8'd16, 8'd16};
        tbl[2]  = '{4'd1, 4'd2,  3'b001, 8'd8,  8'd8};
        tbl[3]  = '{4'd1, 4'd2,  3'b011, 8'd4,  8'd4};
        tbl[4]  = '{4'd1, 4'd2,  3'b111, 8'd2,  8'd2};
        tbl[5]  = '{4'd1, 4'd2,  3'b010, 8'd16, 8'd16};
        tbl[6]  = '{4'd2, 4'd1,  3'b101, 8'd16, 8'd16};
        tbl[7]  = '{4'd3, 4'd5,  3'b111, 8'd8,  8'd16};
        tbl[8]  = '{4'd4, 4'd3,  3'b011, 8'd2,  8'd8};
        tbl[9]  = '{4'd5, 4'd0,  3'b001, 8'd16, 8'd8};
        tbl[10] = '{4'd6, 4'd15, 3'b111, 8'd16, 8'd16};
        tbl[11] = '{4'd9, 4'd4,  3'b001, 8'd16, 8'd2};

        // Reset state
        i_rst  = 1'b1;
        i_en   = 1'b0;
        i_bean = 3'b000;
        i_mode = 8'h00;
        i_sync = 2'b00;
        m0_v = 4'd0; m1_v = 4'd0; bean_v = 3'b000; en_v = 1'b0; sync_v = 2'b00;
        model_reset();
        repeat (3) @(negedge i_clk);
        chk("reset_tick", int'(o_tick), 0);
        chk("reset_period0", int'(o_period[7:0]), 8);
        chk("reset_period1", int'(o_period[15:8]), 8);
        i_rst = 1'b0;

        // Period selection table (counting disabled)
        for (int i = 0; i < 12; i++) begin
            m0_v = tbl[i].m0; m1_v = tbl[i].m1; bean_v = tbl[i].bean; en_v = 1'b0;
            step();
            chk("tbl_period0", int'(o_period[7:0]), int'(tbl[i].e0));
            chk("tbl_period1", int'(o_period[15:8]), int'(tbl[i].e1));
        end

        // Base-rate chase: ticks at edges 16, 32, 48 after the restart
        m0_v = 4'd1; m1_v = 4'd4; bean_v = 3'b000; en_v = 1'b1;
        restart_mark();
        run(50);
        chk("base_period0", int'(o_period[7:0]), 16);
        chk("base_tick_count", log0.size(), 3);
        chk("base_tick_1", (log0.size() > 0) ? log0[0] : -1, 16);
        chk("base_tick_2", (log0.size() > 1) ? log0[1] : -1, 32);
        chk("base_tick_3", (log0.size() > 2) ? log0[2] : -1, 48);

        // Bean ladder on ch0, ch1 eyes running at period 2
        bean_v = 3'b001; run(20);
        chk("bean001_period0", int'(o_period[7:0]), 8);
        bean_v = 3'b011; run(12);
        chk("bean011_period0", int'(o_period[7:0]), 4);
        bean_v = 3'b111; run(4);
        chk("bean111_period0", int'(o_period[7:0]), 2);
        log0.delete(); log1.delete();
        run(8);
        chk("bean111_tick_count0", log0.size(), 4);
        chk("died_tick_count1", log1.size(), 4);
        for (int i = 1; i < 4; i++) begin
            chk("bean111_spacing0", (log0.size() > i) ? log0[i] - log0[i-1] : -1, 2);
            chk("died_spacing1", (log1.size() > i) ? log1[i] - log1[i-1] : -1, 2);
        end

        // Period shortened below the running count: tick on the next edge
        bean_v = 3'b000; sync_v = 2'b01; step();
        run(10);
        chk("pre_shorten_no_tick", int'(o_tick[0]), 0);
        bean_v = 3'b111; step();
        chk("shorten_tick", int'(o_tick[0]), 1);
        step();
        chk("shorten_after_0", int'(o_tick[0]), 0);
        step();
        chk("shorten_after_1", int'(o_tick[0]), 1);

        // Pause mid-period, then resume from a fresh count
        bean_v = 3'b000; sync_v = 2'b01; step();
        run(5);
        log0.delete();
        m0_v = 4'd5; run(20);
        chk("pause_no_ticks", log0.size(), 0);
        m0_v = 4'd1;
        restart_mark();
        run(17);
        chk("resume_tick_count", log0.size(), 1);
        chk("resume_first_tick", (log0.size() > 0) ? log0[0] : -1, 16);

        // Sync on the wrap cycle suppresses the tick and restarts the count
        sync_v = 2'b01; step();
        run(15);
        restart_mark();
        sync_v = 2'b01; step();
        chk("sync_wrap_no_tick", int'(o_tick[0]), 0);
        run(19);
        chk("sync_first_tick", (log0.size() > 0) ? log0[0] : -1, 16);

        // Enable dropped for 7 cycles mid-period delays the tick by 7
        restart_mark();
        sync_v = 2'b01; step();
        run(4);
        en_v = 1'b0; run(7);
        en_v = 1'b1; run(15);
        chk("en_gap_first_tick", (log0.size() > 0) ? log0[0] : -1, 23);

        // Asynchronous reset between edges at cnt=9
        sync_v = 2'b01; step();
        run(9);
        chk("pre_reset_period0", int'(o_period[7:0]), 16);
        #1 i_rst = 1'b1;
        #1;
        chk("async_reset_tick", int'(o_tick), 0);
        chk("async_reset_period0", int'(o_period[7:0]), 8);
        chk("async_reset_period1", int'(o_period[15:8]), 8);
        #1 i_rst = 1'b0;
        #1;
        chk("post_release_period0", int'(o_period[7:0]), 8);
        chk("post_release_period1", int'(o_period[15:8]), 8);
        model_reset();
        restart_mark();
        run(20);
        chk("post_reset_tick_count", log0.size(), 1);
        chk("post_reset_first_tick", (log0.size() > 0) ? log0[0] : -1, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
